reg_file_array: RTL and testbench
=================================

// Module: reg_file_array
// PURPOSE
//  - Storage array of the register file; sits directly downstream of the 4->16 write decoder.
//  - Consumes the decoder's one-hot wordline plus write data and updates the selected register on the clock edge.
//  - Provides two asynchronous read ports (src1/src2) to the decode stage.
//  - R0 is hardwired to zero: the decoder never asserts a wordline for id 0, and reads of R0 return 0.
//  - Flags illegal (multi-hot) wordlines with a sticky error.
// PARAMETERS
//  - DATA_WIDTH  16  width of each register and of all data ports
//  - NUM_REGS    16  number of registers; must equal 2**ID_WIDTH, which is the wordline width
//  - ID_WIDTH    4   width of the read register ids
// PORTS
//  - clk          in   1           single clock, rising edge
//  - rst          in   1           asynchronous, active-high reset
//  - wordline     in   NUM_REGS    one-hot write select from the write decoder; all-zero = no write
//  - write_data   in   DATA_WIDTH  data written to the selected register
//  - src1_id      in   ID_WIDTH    read port 1 register id
//  - src2_id      in   ID_WIDTH    read port 2 register id
//  - src1_data    out  DATA_WIDTH  read port 1 data
//  - src2_data    out  DATA_WIDTH  read port 2 data
//  - wl_err       out  1           sticky: a multi-hot wordline was seen
//  - write_count  out  16          number of writes committed since reset; wraps
// BEHAVIOUR
//  - Reset
//    - rst asserted clears R1..R15, wl_err and write_count to 0 immediately, without waiting for clk.
//    - Reset mid-write: the write is discarded.
//    - First edge after rst deasserts operates normally.
//  - Write, one-cycle latency
//    - At posedge clk with exactly one wordline bit k set (k != 0): R[k] <= write_data; write_count increments.
//    - wordline == 0: no write; count holds.
//    - wordline[0] set alone: no storage change (R0 is constant 0), but the write is still counted.
//  - Multi-hot wordline (popcount >= 2)
//    - No register is written and write_count holds.
//    - wl_err <= 1 at that edge; it stays set until rst.
//  - Read
//    - Combinational, zero latency.
//    - srcN_data = (srcN_id == 0) ? 0 : R[srcN_id], unless the bypass below applies.
//  - Same-cycle write and read, without bypass
//    - The read returns the old value.
//    - The new value is visible on the cycle after the edge.
//  - Both read ports may select the same register; each returns the same value.
//  - write_count wraps 16'hFFFF -> 16'h0000 with no flag.
// CONFIGURATION
//  - Macro: REG_FILE_BYPASS_EN
//  - Defined: write-through bypass.
//    - When the wordline is one-hot at bit k != 0 and srcN_id == k, srcN_data = write_data in the same cycle.
//    - The bypass is combinational from wordline/write_data.
//    - No bypass for id 0, an all-zero wordline, or a multi-hot wordline.
//  - Undefined: reads always return stored contents, with no path from write_data to srcN_data.
//  - All other behaviour is identical in both builds.
// TESTING
//  - Reset: write 16'hBEEF to R5, assert rst between edges
//    -> src1_data for id 5 reads 0 immediately; wl_err = 0, write_count = 0.
//  - Basic write: wordline = 16'h0020, write_data = 16'h1234, edge
//    -> src1_id = 5 reads 16'h1234; write_count = 1; other registers remain 0.
//  - R0: wordline = 16'h0001, write_data = 16'hFFFF, edge -> src2_id = 0 reads 0.
//  - Multi-hot: wordline = 16'h0104, write_data = 16'hAAAA, edge
//    -> R2 and R8 unchanged, wl_err = 1, write_count unchanged.
//    -> wl_err is still 1 after 10 clean writes.
//  - Bypass: wordline = 16'h0080, write_data = 16'h5A5A, src1_id = 7 before the edge
//    -> with REG_FILE_BYPASS_EN: src1_data = 16'h5A5A; without it: old R7.
//    -> after the edge, both builds read 16'h5A5A.
//  - Wrap: 65536 single-hot writes -> write_count returns to 16'h0000.

Source files
------------

// File: rtl/reg_file_array.sv
// reg_file_array: register file storage with hardwired-zero R0, two async read ports and a sticky multi-hot error.
// Optional write-through bypass when REG_FILE_BYPASS_EN is defined.
module reg_file_array #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REGS-1:0]   wordline,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ID_WIDTH-1:0]   src1_id,
  input  logic [ID_WIDTH-1:0]   src2_id,
  output logic [DATA_WIDTH-1:0] src1_data,
  output logic [DATA_WIDTH-1:0] src2_data,
  output logic                  wl_err,
  output logic [15:0]           write_count
);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic one_hot;
  logic multi_hot;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  assign one_hot   = (wordline != '0) && ((wordline & (wordline - NUM_REGS'(1))) == '0);
  assign multi_hot = (wordline != '0) && !one_hot;
  // regs[0] is never written, so it stays the constant zero that R0 reads as
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wl_err      <= 1'b0;
      write_count <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (one_hot && wordline[i]) regs[i] <= write_data;
      if (one_hot) write_count <= write_count + 16'd1;
      if (multi_hot) wl_err <= 1'b1;
    end
  end
  assign rd1 = (src1_id == '0) ? '0 : regs[src1_id];
  assign rd2 = (src2_id == '0) ? '0 : regs[src2_id];
`ifdef REG_FILE_BYPASS_EN
  assign src1_data = (one_hot && src1_id != '0 && wordline[src1_id]) ? write_data : rd1;
  assign src2_data = (one_hot && src2_id != '0 && wordline[src2_id]) ? write_data : rd2;
`else
  assign src1_data = rd1;
  assign src2_data = rd2;
`endif
endmodule

// File: tb/tb_reg_file_array.sv
// tb_reg_file_array: directed self-checking bench for reg_file_array.
module tb_reg_file_array;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wordline;
  logic [15:0] write_data;
  logic [3:0]  src1_id;
  logic [3:0]  src2_id;
  logic [15:0] src1_data;
  logic [15:0] src2_data;
  logic        wl_err;
  logic [15:0] write_count;
  int errors = 0;
  int checks = 0;

  reg_file_array dut (
    .clk(clk), .rst(rst), .wordline(wordline), .write_data(write_data),
    .src1_id(src1_id), .src2_id(src2_id), .src1_data(src1_data),
    .src2_data(src2_data), .wl_err(wl_err), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [15:0] wl, input logic [15:0] d);
    wordline = wl;
    write_data = d;
    tick();
    wordline = '0;
  endtask

  initial begin
    rst = 1'b1;
    wordline = '0;
    write_data = '0;
    src1_id = 4'd5;
    src2_id = 4'd0;
    tick();
    check("rst_r5", src1_data, 16'h0000);
    check("rst_err", {15'd0, wl_err}, 16'd0);
    check("rst_cnt", write_count, 16'd0);
    rst = 1'b0;
    tick();
    write(16'h0020, 16'hBEEF);
    check("beef_r5", src1_data, 16'hBEEF);
    check("beef_cnt", write_count, 16'd1);
    #2 rst = 1'b1;
    #1;
    check("async_r5", src1_data, 16'h0000);
    check("async_cnt", write_count, 16'd0);
    check("async_err", {15'd0, wl_err}, 16'd0);
    #1 rst = 1'b0;
    tick();
    wordline = 16'h0020;
    write_data = 16'h1234;
    src1_id = 4'd5;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("pre_r5", src1_data, 16'h1234);
`else
    check("pre_r5", src1_data, 16'h0000);
`endif
    tick();
    wordline = '0;
    check("basic_r5", src1_data, 16'h1234);
    check("basic_cnt", write_count, 16'd1);
    src1_id = 4'd3;
    src2_id = 4'd15;
    #1;
    check("basic_r3", src1_data, 16'h0000);
    check("basic_r15", src2_data, 16'h0000);
    write(16'h0001, 16'hFFFF);
    src2_id = 4'd0;
    #1;
    check("r0_read", src2_data, 16'h0000);
    check("r0_cnt", write_count, 16'd2);
    write(16'h0004, 16'h2222);
    write(16'h0100, 16'h8888);
    wordline = 16'h0104;
    write_data = 16'hAAAA;
    src1_id = 4'd2;
    src2_id = 4'd8;
    #1;
    check("mh_pre_r2", src1_data, 16'h2222);
    tick();
    wordline = '0;
    check("mh_r2", src1_data, 16'h2222);
    check("mh_r8", src2_data, 16'h8888);
    check("mh_err", {15'd0, wl_err}, 16'd1);
    check("mh_cnt", write_count, 16'd4);
    for (int i = 1; i <= 10; i++) write(16'(1 << i), 16'(i * 16'h0111));
    src1_id = 4'd3;
    #1;
    check("clean_r3", src1_data, 16'h0333);
    check("clean_err", {15'd0, wl_err}, 16'd1);
    check("clean_cnt", write_count, 16'd14);
    wordline = 16'h0080;
    write_data = 16'h5A5A;
    src1_id = 4'd7;
    src2_id = 4'd7;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("byp_src1", src1_data, 16'h5A5A);
    check("byp_src2", src2_data, 16'h5A5A);
`else
    check("byp_src1", src1_data, 16'h0777);
    check("byp_src2", src2_data, 16'h0777);
`endif
    tick();
    wordline = '0;
    check("post_src1", src1_data, 16'h5A5A);
    check("post_src2", src2_data, 16'h5A5A);
    check("post_cnt", write_count, 16'd15);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    check("wrap_start", write_count, 16'd0);
    wordline = 16'h0002;
    write_data = 16'h4321;
    repeat (65535) @(posedge clk);
    #1;
    check("wrap_ffff", write_count, 16'hFFFF);
    tick();
    wordline = '0;
    check("wrap_zero", write_count, 16'h0000);
    check("wrap_err", {15'd0, wl_err}, 16'd0);
    src1_id = 4'd1;
    #1;
    check("wrap_r1", src1_data, 16'h4321);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
